fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I pipeline. It holds the PC and issues requests to instruction memory over a variable-latency req/ready handshake. It loads the fetched word into the D-stage register, where the opcode field InstrD[6:0] drives the main control decoder. It also handles hazard-unit stall and flush, and branch/jump redirects from E.

---
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
// Holds PCF and fetches from instruction memory over a req/ready
// handshake, loads the D-stage register, and handles hazard stall/flush
// and E-stage redirects.
//
// States: FETCH (request at PCF), HOLD (stalled word parked in a skid
// buffer, no request), DROP (finishing a request abandoned by a redirect).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   StallD, FlushD        hazard-unit hold / bubble for IF/ID
//   PCSrcE, PCTargetE     redirect from E (target bits [1:0] ignored)
//   imem_req, imem_addr   fetch request and word-aligned address
//   imem_rdata, imem_ready  returned word, completes when req && ready
//   InstrD, PCD, PCPlus4D, ValidD  D-stage register outputs
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

    localparam logic [XLEN-1:0] FOUR  = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;
    logic            valid_q, valid_d;

    logic            done;
    logic            ld_new, ld_bub;
    logic [31:0]     new_instr;
    logic [XLEN-1:0] new_pc;

    // No request while parked in HOLD or while reset is asserted.
    assign imem_req  = !reset && (state_q != S_HOLD);
    // DROP keeps presenting the abandoned address until it completes.
    assign imem_addr = (state_q == S_DROP) ? req_addr_q : pcf_q;
    assign done      = imem_req && imem_ready;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        req_addr_d   = (state_q == S_FETCH) ? pcf_q : req_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ld_new       = 1'b0;
        ld_bub       = 1'b0;
        new_instr    = imem_rdata;
        new_pc       = pcf_q;

        case (state_q)
            S_HOLD: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE & ALIGN;
                    ld_bub  = 1'b1;
                    state_d = S_FETCH;
                end else if (FlushD) begin
                    // Keep the parked word; it is released once unflushed.
                    ld_bub = 1'b1;
                end else if (!StallD) begin
                    ld_new    = 1'b1;
                    new_instr = skid_instr_q;
                    new_pc    = skid_pc_q;
                    pcf_d     = skid_pc_q + FOUR;
                    state_d   = S_FETCH;
                end
            end
            S_DROP: begin
                if (PCSrcE) pcf_d = PCTargetE & ALIGN;
                if (done) state_d = S_FETCH;
                ld_bub = PCSrcE || FlushD || !StallD;
            end
            default: begin // S_FETCH
                if (PCSrcE) begin
                    pcf_d   = PCTargetE & ALIGN;
                    ld_bub  = 1'b1;
                    state_d = done ? S_FETCH : S_DROP;
                end else if (done) begin
                    if (!StallD && !FlushD) begin
                        ld_new = 1'b1;
                        pcf_d  = pcf_q + FOUR;
                    end else begin
                        // Word cannot enter IF/ID now; park it so it is not lost.
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pcf_q;
                        state_d      = S_HOLD;
                        ld_bub       = FlushD;
                    end
                end else begin
                    ld_bub = FlushD || !StallD;
                end
            end
        endcase

        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (ld_new) begin
            instr_d = new_instr;
            pcd_d   = new_pc;
            pcp4_d  = new_pc + FOUR;
            valid_d = 1'b1;
        end else if (ld_bub) begin
            instr_d = NOP_INSTR;
            pcd_d   = '0;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pcf_q        <= RESET_PC;
            req_addr_q   <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            instr_q      <= NOP_INSTR;
            pcd_q        <= '0;
            pcp4_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            req_addr_q   <= req_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            pcp4_q       <= pcp4_d;
            valid_q      <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. Memory model: word at address A is A+0x100.
// Expected D-stage entries are queued by the stimulus; a monitor pops one
// whenever a new valid instruction enters D (ValidD after an unstalled edge).
// A second instance with RESET_PC=0xFFFFFFFC checks PC wrap-around.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req, imem_ready = 1'b1;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    logic        req1, ValidD1;
    logic [31:0] addr1, rdata1, InstrD1, PCD1, PCPlus4D1;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr + 32'h100;
    assign rdata1     = addr1 + 32'h100;

    fetch_stage dut (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .StallD(1'b0), .FlushD(1'b0),
        .PCSrcE(1'b0), .PCTargetE(32'h0),
        .imem_req(req1), .imem_addr(addr1),
        .imem_rdata(rdata1), .imem_ready(1'b1),
        .InstrD(InstrD1), .PCD(PCD1), .PCPlus4D(PCPlus4D1), .ValidD(ValidD1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        sb.push_back('{pc: pc, instr: pc + 32'h100, pcp4: pc + 32'h4});
    endtask

    // Monitor: a new D entry exists only if the edge was not stalled.
    always @(posedge clk) begin
        logic stalled;
        exp_t e;
        stalled = StallD;
        #2;
        if (ValidD && !stalled) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got PCD=%h InstrD=%h expected no instruction", PCD, InstrD);
            end else begin
                e = sb.pop_front();
                chk("PCD", PCD, e.pc);
                chk("InstrD", InstrD, e.instr);
                chk("PCPlus4D", PCPlus4D, e.pcp4);
            end
        end else if (!ValidD) begin
            chk("bubble_InstrD", InstrD, NOP);
        end
    end

    initial begin
        // Reset for two cycles, zero-wait memory.
        step();
        step();
        chk("reset_req", {31'b0, imem_req}, 32'h0);
        chk("reset_ValidD", {31'b0, ValidD}, 32'h0);
        chk("reset_PCD", PCD, 32'h0);
        chk("reset_PCPlus4D", PCPlus4D, 32'h0);
        chk("reset_InstrD", InstrD, NOP);
        reset = 1'b0;
        push(32'h0); push(32'h4); push(32'h8);
        step();
        chk("wrap_PCD0", PCD1, 32'hFFFF_FFFC);
        chk("wrap_Instr0", InstrD1, 32'h0000_00FC);
        chk("wrap_PCPlus4D0", PCPlus4D1, 32'h0);
        chk("wrap_Valid0", {31'b0, ValidD1}, 32'h1);
        step();
        chk("wrap_PCD1", PCD1, 32'h0);
        chk("wrap_Instr1", InstrD1, 32'h100);
        chk("wrap_PCPlus4D1", PCPlus4D1, 32'h4);
        step();

        // Ready every third cycle: address held, bubbles between words.
        push(32'hC); push(32'h10); push(32'h14);
        for (int i = 0; i < 9; i++) begin
            imem_ready = (i % 3 == 2);
            chk("wait_addr", imem_addr, 32'hC + 32'(4 * (i / 3)));
            chk("wait_req", {31'b0, imem_req}, 32'h1);
            step();
        end

        // Stall for three cycles while the 0x18 request completes.
        imem_ready = 1'b1;
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_req", {31'b0, imem_req}, 32'h0);
            chk("hold_PCD", PCD, 32'h14);
        end
        StallD = 1'b0;
        push(32'h18);
        step();
        chk("after_hold_addr", imem_addr, 32'h1C);
        push(32'h1C);
        step();

        // Redirect to 0x203 while the 0x20 request is pending.
        imem_ready = 1'b0;
        PCSrcE = 1'b1;
        PCTargetE = 32'h203;
        chk("pending_addr", imem_addr, 32'h20);
        step();
        PCSrcE = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drop_addr", imem_addr, 32'h20);
            chk("drop_req", {31'b0, imem_req}, 32'h1);
            step();
        end
        imem_ready = 1'b1;
        chk("drop_addr_done", imem_addr, 32'h20);
        step();
        chk("target_addr", imem_addr, 32'h200);
        push(32'h200);
        step();

        // Redirect together with stall while in HOLD.
        StallD = 1'b1;
        step();
        chk("hold2_req", {31'b0, imem_req}, 32'h0);
        PCSrcE = 1'b1;
        PCTargetE = 32'h400;
        step();
        chk("redir_hold_ValidD", {31'b0, ValidD}, 32'h0);
        chk("redir_hold_addr", imem_addr, 32'h400);
        PCSrcE = 1'b0;
        StallD = 1'b0;
        push(32'h400);
        step();

        // Flush coinciding with completion: word parked, then delivered.
        FlushD = 1'b1;
        step();
        chk("flush_req", {31'b0, imem_req}, 32'h0);
        chk("flush_ValidD", {31'b0, ValidD}, 32'h0);
        FlushD = 1'b0;
        push(32'h404);
        step();
        push(32'h408);
        step();
        imem_ready = 1'b0;
        step();
        step();
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
